// File: rtl/branch_target_fetch_sequencer_pkg.sv
// Shared definitions for the branch target fetch sequencer.
//
// Contents:
//   fetch_state_t - fetch FSM state encoding (REQ / WAIT / HOLD)
//   PcIncrement   - byte distance between consecutive instruction words
//   AlignMask     - low address bits forced to zero on a redirect
package branch_target_fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_t;

    localparam int unsigned PcIncrement = 4;
    localparam int unsigned AlignMask   = 3;

endpackage

// File: rtl/branch_target_fetch_output_buffer.sv
// Holding register between the fetch sequencer and decode.
//
// Ports:
//   Clock, Reset          - rising-edge clock, synchronous active-high reset
//   Advance               - global enable; nothing changes when low
//   Load, LoadData, LoadPC - capture a fetched word and its address
//   Flush                 - drop the held word (redirect)
//   Consume               - decode took the held word
//   InstrValid/Data/PC    - held instruction presented to decode
module fetch_output_buffer #(
    parameter int NrOfBits  = 32,
    parameter int InstrBits = 32
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Advance,
    input  logic                 Load,
    input  logic                 Flush,
    input  logic                 Consume,
    input  logic [InstrBits-1:0] LoadData,
    input  logic [NrOfBits-1:0]  LoadPC,
    output logic                 InstrValid,
    output logic [InstrBits-1:0] InstrData,
    output logic [NrOfBits-1:0]  InstrPC
);

    // Flush outranks load and consume so a redirect can never let a stale
    // word reach decode. Data and PC are left alone on flush/consume since
    // they are meaningless once InstrValid is low.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            InstrValid <= 1'b0;
            InstrData  <= '0;
            InstrPC    <= '0;
        end else if (Advance) begin
            if (Flush) begin
                InstrValid <= 1'b0;
            end else if (Load) begin
                InstrValid <= 1'b1;
                InstrData  <= LoadData;
                InstrPC    <= LoadPC;
            end else if (Consume) begin
                InstrValid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/branch_target_fetch_sequencer.sv
// Fetch sequencer: owns the program counter, issues one instruction-memory
// request at a time, hands fetched words to decode and handles branch
// redirects (squashing a fetch that is already in flight).
//
// Ports:
//   Clock, Reset, ClockEnable, Tick - clocking; advance = ClockEnable & Tick
//   BranchTaken, BranchAddr         - redirect strobe and destination
//   ImemReq*                        - fetch request (valid/ready, address)
//   ImemRsp*                        - fetch response (valid, data)
//   Instr*                          - instruction to decode (valid/ready)
//   PC                              - current program counter
module branch_target_fetch_sequencer
    import branch_target_fetch_sequencer_pkg::*;
#(
    parameter int                  NrOfBits    = 32,
    parameter int                  InstrBits   = 32,
    parameter logic [NrOfBits-1:0] ResetVector = '0
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 ClockEnable,
    input  logic                 Tick,
    input  logic                 BranchTaken,
    input  logic [NrOfBits-1:0]  BranchAddr,
    output logic                 ImemReqValid,
    output logic [NrOfBits-1:0]  ImemReqAddr,
    input  logic                 ImemReqReady,
    input  logic                 ImemRspValid,
    input  logic [InstrBits-1:0] ImemRspData,
    output logic                 InstrValid,
    output logic [InstrBits-1:0] InstrData,
    output logic [NrOfBits-1:0]  InstrPC,
    input  logic                 InstrReady,
    output logic [NrOfBits-1:0]  PC
);

    fetch_state_t        state, state_next;
    logic [NrOfBits-1:0] pc, pc_next;
    logic                squash, squash_next;
    logic                advance, redirect, req_hs, rsp_seen, dec_hs;
    logic                buf_load, buf_flush, buf_consume;
    logic [NrOfBits-1:0] branch_target;

    assign advance       = ClockEnable & Tick;
    assign redirect      = BranchTaken & advance;
    assign req_hs        = ImemReqValid & ImemReqReady & advance;
    assign rsp_seen      = ImemRspValid & advance;
    assign dec_hs        = InstrValid & InstrReady & advance;
    assign branch_target = BranchAddr & ~NrOfBits'(AlignMask);

    assign ImemReqValid = (state == ST_REQ);
    assign ImemReqAddr  = pc;
    assign PC           = pc;

    // State, PC and squash flag only move on advance cycles; every
    // transition condition below already includes advance, the enable
    // here just makes the hold explicit.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= ST_REQ;
            pc     <= ResetVector;
            squash <= 1'b0;
        end else if (advance) begin
            state  <= state_next;
            pc     <= pc_next;
            squash <= squash_next;
        end
    end

    // Next-state logic. A redirect wins over the normal transition. In WAIT,
    // any response arriving alongside a redirect (or while squash is set)
    // belongs to a stale request, so it is dropped and a fresh request is
    // issued from the new PC; a redirect without a response arms squash so
    // the eventual stale response is swallowed.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        squash_next = squash;
        buf_load    = 1'b0;
        buf_flush   = 1'b0;
        buf_consume = 1'b0;

        case (state)
            ST_REQ: begin
                if (req_hs) begin
                    state_next = ST_WAIT;
                    if (redirect) squash_next = 1'b1;
                end
            end
            ST_WAIT: begin
                if (rsp_seen && (squash || redirect)) begin
                    squash_next = 1'b0;
                    state_next  = ST_REQ;
                end else if (redirect) begin
                    squash_next = 1'b1;
                end else if (rsp_seen) begin
                    buf_load   = 1'b1;
                    pc_next    = pc + NrOfBits'(PcIncrement);
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    buf_flush  = 1'b1;
                    state_next = ST_REQ;
                end else if (dec_hs) begin
                    buf_consume = 1'b1;
                    state_next  = ST_REQ;
                end
            end
            default: begin
                state_next = ST_REQ;
            end
        endcase

        if (redirect) pc_next = branch_target;
    end

    fetch_output_buffer #(
        .NrOfBits (NrOfBits),
        .InstrBits(InstrBits)
    ) u_output_buffer (
        .Clock     (Clock),
        .Reset     (Reset),
        .Advance   (advance),
        .Load      (buf_load),
        .Flush     (buf_flush),
        .Consume   (buf_consume),
        .LoadData  (ImemRspData),
        .LoadPC    (pc),
        .InstrValid(InstrValid),
        .InstrData (InstrData),
        .InstrPC   (InstrPC)
    );

endmodule
